fetch_stage: RTL and testbench

Instruction fetch stage with a small prefetch queue, sitting upstream of the instruction register/decoder in the pipelined CPU. It owns the fetch PC and issues one word-addressed request per cycle to the instruction memory, which has a fixed one-cycle read latency. It buffers returned words with their PCs and hands them to decode over a valid/ready handshake. It supports redirect (jump/branch/jreg target) and halt.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset fetch address and the prefetch entry layout.
package cpu_pkg;

    localparam int unsigned BITS = 32;
    localparam logic [BITS-1:0] I_MEM_BASE_ADDR = '0;

    typedef struct packed {
        logic [BITS-1:0] pc;
        logic [BITS-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head reads as zero when empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  fetch_entry_t        din,
    output fetch_entry_t        dout,
    output logic [CntW-1:0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t           mem_q [DEPTH];
    fetch_entry_t           mem_d [DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the occupancy count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues credit-limited requests to a one-cycle imem
// and queues returned words with their PCs for decode.
module fetch_stage #(
    parameter logic [cpu_pkg::BITS-1:0] I_MEM_BASE_ADDR = cpu_pkg::I_MEM_BASE_ADDR,
    parameter int unsigned              DEPTH           = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    output logic [cpu_pkg::BITS-1:0] imem_addr,
    output logic                     imem_req,
    input  logic [cpu_pkg::BITS-1:0] imem_rdata,
    output logic [cpu_pkg::BITS-1:0] instr,
    output logic [cpu_pkg::BITS-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [cpu_pkg::BITS-1:0] redirect_pc,
    input  logic                     halt
);

    import cpu_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned CW   = CntW + 1;

    logic [BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [BITS-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            pop, push;
    logic [CntW-1:0] count;
    logic [CW-1:0]   credit_used;
    fetch_entry_t    din, head;

    always_comb begin
        pop  = instr_valid & instr_ready & ~redirect;
        push = inflight_q & ~redirect;
        // Slots committed after this edge; counting the pop lets a full queue refill at once.
        credit_used = CW'(count) + CW'(inflight_q) - CW'(pop);
        imem_req    = rst_ & ~redirect & ~halt & (credit_used < CW'(DEPTH));

        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imem_req;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + BITS'(1);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            fetch_pc_q    <= I_MEM_BASE_ADDR;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    assign din = '{pc: inflight_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_fetch_stage;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] WORD_BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(
        .I_MEM_BASE_ADDR (BASE),
        .DEPTH           (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address a is WORD_BASE + a, one-cycle read latency.
    always @(posedge clk) imem_rdata <= WORD_BASE + imem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds what decode should see, in order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc      = BASE;
    logic [31:0] m_pend_pc = '0;
    bit          m_pend    = 1'b0;
    bit          chk_en    = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_valid, e_pop, e_req;
            logic [31:0] e_instr, e_pc;
            int          used;
            e_valid = (mq.size() != 0);
            e_instr = e_valid ? mq[0].instr : 32'h0;
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_pop   = e_valid && instr_ready && !redirect;
            used    = mq.size() - int'(e_pop) + int'(m_pend);
            e_req   = rst_ && !redirect && !halt && (used < int'(DEPTH));

            check("model_valid", {31'b0, instr_valid}, {31'b0, e_valid});
            check("model_instr", instr, e_instr);
            check("model_pc", instr_pc, e_pc);
            check("model_req", {31'b0, imem_req}, {31'b0, e_req});
            check("model_addr", imem_addr, m_pc);

            if (!rst_) begin
                mq.delete();
                m_pend = 1'b0;
                m_pc   = BASE;
            end else if (redirect) begin
                mq.delete();
                m_pend = 1'b0;
                m_pc   = redirect_pc;
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (m_pend) mq.push_back('{pc: m_pend_pc, instr: WORD_BASE + m_pend_pc});
                m_pend = e_req;
                if (e_req) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        rst_        = 1'b0;
        instr_ready = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        cyc();
        chk_en = 1'b1;
        cyc();

        // Reset release: cycle 0 requests base, cycle 2 first valid.
        rst_ = 1'b1;
        samp();
        check("c0_req", {31'b0, imem_req}, 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", {31'b0, instr_valid}, 32'd0);
        cyc();
        samp();
        check("c1_valid", {31'b0, instr_valid}, 32'd0);
        cyc();
        samp();
        check("c2_valid", {31'b0, instr_valid}, 32'd1);
        check("c2_pc", instr_pc, 32'h0);
        check("c2_instr", instr, 32'h1000_0000);
        cyc();
        samp();
        check("c3_pc", instr_pc, 32'h1);
        check("c3_instr", instr, 32'h1000_0001);
        repeat (4) cyc();

        // Backpressure from cycle 2 of a fresh start: exactly DEPTH requests.
        rst_ = 1'b0;
        cyc();
        rst_ = 1'b1;
        reqs = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) instr_ready = 1'b0;
            samp();
            reqs += int'(imem_req);
            if (c == 11) check("stall_head_pc", instr_pc, 32'h0);
            cyc();
        end
        check("stall_reqs", reqs, 32'd4);
        instr_ready = 1'b1;
        samp();
        check("unstall_req", {31'b0, imem_req}, 32'd1);
        check("unstall_addr", imem_addr, 32'h4);
        repeat (6) cyc();

        // Redirect from a full queue while decode is also ready.
        instr_ready = 1'b0;
        repeat (6) cyc();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        samp();
        check("r1_valid", {31'b0, instr_valid}, 32'd0);
        check("r1_addr", imem_addr, 32'h40);
        check("r1_req", {31'b0, imem_req}, 32'd1);
        cyc();
        samp();
        check("r2_valid", {31'b0, instr_valid}, 32'd0);
        cyc();
        samp();
        check("r3_valid", {31'b0, instr_valid}, 32'd1);
        check("r3_pc", instr_pc, 32'h40);
        check("r3_instr", instr, 32'h1000_0040);
        repeat (2) cyc();

        // Redirect under halt: no requests until halt falls, then at redirect_pc.
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            check("halt_redir_req", {31'b0, imem_req}, 32'd0);
            cyc();
        end
        halt = 1'b0;
        samp();
        check("halt_redir_addr", imem_addr, 32'h80);
        check("halt_redir_req1", {31'b0, imem_req}, 32'd1);
        repeat (3) cyc();

        // Halt with two queued and one in flight.
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        repeat (3) cyc();
        halt        = 1'b1;
        instr_ready = 1'b1;
        samp();
        check("h_req", {31'b0, imem_req}, 32'd0);
        check("h_pc0", instr_pc, 32'h100);
        cyc();
        samp();
        check("h_pc1", instr_pc, 32'h101);
        cyc();
        samp();
        check("h_pc2", instr_pc, 32'h102);
        cyc();
        samp();
        check("h_empty", {31'b0, instr_valid}, 32'd0);
        cyc();
        halt = 1'b0;
        samp();
        check("h_resume_addr", imem_addr, 32'h103);
        check("h_resume_req", {31'b0, imem_req}, 32'd1);
        repeat (3) cyc();

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        samp();
        check("wrap_a0", imem_addr, 32'hFFFF_FFFE);
        cyc();
        samp();
        check("wrap_a1", imem_addr, 32'hFFFF_FFFF);
        cyc();
        samp();
        check("wrap_a2", imem_addr, 32'h0);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFE);
        repeat (4) cyc();

        // One-cycle reset mid-stream.
        rst_ = 1'b0;
        samp();
        check("rst_low_req", {31'b0, imem_req}, 32'd0);
        cyc();
        rst_ = 1'b1;
        samp();
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_addr", imem_addr, BASE);
        check("rst_req", {31'b0, imem_req}, 32'd1);
        cyc();
        cyc();
        samp();
        check("rst_c2_pc", instr_pc, BASE);
        check("rst_c2_valid", {31'b0, instr_valid}, 32'd1);
        repeat (4) cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
